// File: rtl/mem_bus_arb.sv
// mem_bus_arb: two-requester round-robin arbiter onto one pipelined memory bus.
module mem_bus_arb #(
  parameter int p_st_bits = 32,
  parameter int p_addr_bits = 32,
  parameter int p_max_rd = 4,
  parameter int p_max_rd_log2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req0_read,
  input  logic                     i_req0_write,
  input  logic [p_addr_bits-1:0]   i_req0_addr,
  input  logic [p_st_bits-1:0]     i_req0_writedata,
  output logic                     o_req0_ack,
  output logic [p_st_bits-1:0]     o_req0_readdata,
  output logic                     o_req0_valid,
  input  logic                     i_req1_read,
  input  logic                     i_req1_write,
  input  logic [p_addr_bits-1:0]   i_req1_addr,
  input  logic [p_st_bits-1:0]     i_req1_writedata,
  output logic                     o_req1_ack,
  output logic [p_st_bits-1:0]     o_req1_readdata,
  output logic                     o_req1_valid,
  output logic                     o_read,
  output logic                     o_write,
  output logic [p_addr_bits-1:0]   o_addr,
  output logic [p_st_bits-1:0]     o_writedata,
  input  logic [p_st_bits-1:0]     i_readdata,
  input  logic                     i_readdatavalid,
  input  logic                     i_waitrequest,
  output logic [p_max_rd_log2:0]   o_rd_pending,
  output logic                     o_err
);
  localparam int l_w = p_max_rd_log2 + 1;
  localparam logic [p_max_rd_log2:0] l_max = l_w'(p_max_rd);
  logic rr_q, rr_d, lock_q, lock_d, own_q, own_d, err_q, err_d;
  logic [p_max_rd-1:0] fifo_q, fifo_d;
  logic [p_max_rd_log2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [p_max_rd_log2:0] cnt_q, cnt_d;
  logic elig0, elig1, sel, sel_v, rd, wr, acc, push, pop, head;
  always_comb begin
    elig0 = (i_req0_read & (cnt_q < l_max)) | (i_req0_write & ~i_req0_read);
    elig1 = (i_req1_read & (cnt_q < l_max)) | (i_req1_write & ~i_req1_read);
    sel = lock_q ? own_q : (elig0 & elig1) ? rr_q : elig1;
    sel_v = ~rst & (lock_q | elig0 | elig1);
    rd = sel_v & (sel ? i_req1_read : i_req0_read);
    wr = sel_v & ~rd & (sel ? i_req1_write : i_req0_write);
    acc = (rd | wr) & ~i_waitrequest;
    push = acc & rd;
    pop = ~rst & i_readdatavalid & (cnt_q != '0);
    head = fifo_q[rptr_q];
    rr_d = acc ? ~sel : rr_q;
    lock_d = (rd | wr) & i_waitrequest;
    own_d = sel;
    fifo_d = fifo_q;
    if (push) fifo_d[wptr_q] = sel;
    wptr_d = wptr_q + p_max_rd_log2'(push);
    rptr_d = rptr_q + p_max_rd_log2'(pop);
    cnt_d = cnt_q + l_w'(push) - l_w'(pop);
    err_d = err_q | (i_readdatavalid & (cnt_q == '0));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
      lock_q <= 1'b0;
      own_q <= 1'b0;
      err_q <= 1'b0;
      fifo_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      rr_q <= rr_d;
      lock_q <= lock_d;
      own_q <= own_d;
      err_q <= err_d;
      fifo_q <= fifo_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign o_read = rd;
  assign o_write = wr;
  assign o_addr = sel ? i_req1_addr : i_req0_addr;
  assign o_writedata = sel ? i_req1_writedata : i_req0_writedata;
  assign o_req0_ack = acc & ~sel;
  assign o_req1_ack = acc & sel;
  assign o_req0_valid = pop & ~head;
  assign o_req1_valid = pop & head;
  assign o_req0_readdata = i_readdata;
  assign o_req1_readdata = i_readdata;
  assign o_rd_pending = cnt_q;
  assign o_err = err_q;
endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb: directed bench with an owner scoreboard for read responses.
module tb_mem_bus_arb;
  logic clk = 0, rst = 1;
  logic r0 = 0, w0 = 0, r1 = 0, w1 = 0;
  logic [31:0] a0 = 0, d0 = 0, a1 = 0, d1 = 0;
  logic ack0, ack1, v0, v1, o_read, o_write, rdv = 0, wait_r = 0, o_err;
  logic [31:0] rd0, rd1, o_addr, o_wd, rdata = 0;
  logic [2:0] pend;
  int n_vec = 0, n_err = 0;
  bit sb[$];
  always #5 clk = ~clk;
  mem_bus_arb dut (
    .clk(clk), .rst(rst),
    .i_req0_read(r0), .i_req0_write(w0), .i_req0_addr(a0), .i_req0_writedata(d0),
    .o_req0_ack(ack0), .o_req0_readdata(rd0), .o_req0_valid(v0),
    .i_req1_read(r1), .i_req1_write(w1), .i_req1_addr(a1), .i_req1_writedata(d1),
    .o_req1_ack(ack1), .o_req1_readdata(rd1), .o_req1_valid(v1),
    .o_read(o_read), .o_write(o_write), .o_addr(o_addr), .o_writedata(o_wd),
    .i_readdata(rdata), .i_readdatavalid(rdv), .i_waitrequest(wait_r),
    .o_rd_pending(pend), .o_err(o_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic idle();
    r0 = 0; w0 = 0; r1 = 0; w1 = 0; rdv = 0; wait_r = 0;
  endtask
  task automatic do_reset();
    cyc(); idle(); rst = 1; #2; rst = 0;
    sb.delete();
  endtask
  task automatic grant(input string tag, input int e, input bit is_rd);
    chk({tag, "_ack0"}, 32'(ack0), 32'(e == 0));
    chk({tag, "_ack1"}, 32'(ack1), 32'(e == 1));
    if (e >= 0) begin
      chk({tag, "_addr"}, o_addr, e ? a1 : a0);
      chk({tag, "_rd"}, 32'(o_read), 32'(is_rd));
      if (is_rd) sb.push_back(e[0]);
    end
  endtask
  task automatic rsp(input string tag, input logic [31:0] data);
    bit o;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    o = sb.pop_front();
    chk({tag, "_v0"}, 32'(v0), 32'(!o));
    chk({tag, "_v1"}, 32'(v1), 32'(o));
    chk({tag, "_data"}, o ? rd1 : rd0, data);
  endtask
  initial begin
    r0 = 1; a0 = 32'h44;
    #3;
    chk("rst_read", 32'(o_read), 0);
    chk("rst_write", 32'(o_write), 0);
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_err", 32'(o_err), 0);
    do_reset();
    // single read, response two cycles after accept
    cyc(); r0 = 1; a0 = 32'h10; #1; grant("t1", 0, 1);
    cyc(); r0 = 0; #1; chk("t1_pend1", 32'(pend), 1);
    cyc(); rdv = 1; rdata = 32'hCAFE; #1; rsp("t1_rsp", 32'hCAFE);
    cyc(); rdv = 0; #1; chk("t1_pend0", 32'(pend), 0);
    // continuous reads from both alternate
    do_reset();
    a0 = 32'h100; a1 = 32'h200;
    for (int i = 0; i < 4; i++) begin
      cyc(); r0 = 1; r1 = 1; #1; grant($sformatf("t2_g%0d", i), i % 2, 1);
    end
    cyc(); r0 = 0; r1 = 0; #1; chk("t2_pend4", 32'(pend), 4);
    for (int i = 1; i <= 4; i++) begin
      rdv = 1; rdata = 32'(i); #1; rsp($sformatf("t2_r%0d", i), 32'(i));
      cyc();
    end
    rdv = 0; #1; chk("t2_pend0", 32'(pend), 0);
    // stalled write holds the bus against a higher-priority read
    do_reset();
    cyc(); w1 = 1; a1 = 32'h55; d1 = 32'hBEEF; wait_r = 1; #1;
    grant("t3_c1", -1, 0);
    chk("t3_c1_wr", 32'(o_write), 1);
    for (int i = 2; i <= 3; i++) begin
      cyc(); r0 = 1; a0 = 32'h20; #1;
      grant($sformatf("t3_c%0d", i), -1, 0);
      chk($sformatf("t3_c%0d_wr", i), 32'(o_write), 1);
      chk($sformatf("t3_c%0d_addr", i), o_addr, 32'h55);
      chk($sformatf("t3_c%0d_wd", i), o_wd, 32'hBEEF);
    end
    cyc(); wait_r = 0; #1; grant("t3_c4", 1, 0);
    chk("t3_c4_wd", o_wd, 32'hBEEF);
    cyc(); w1 = 0; #1; grant("t3_c5", 0, 1);
    cyc(); r0 = 0; #1;
    cyc(); rdv = 1; rdata = 32'h7; #1; rsp("t3_rsp", 32'h7);
    cyc(); rdv = 0;
    // outstanding limit blocks reads but not writes
    do_reset();
    a0 = 32'h300;
    for (int i = 0; i < 4; i++) begin
      cyc(); r0 = 1; #1; grant($sformatf("t4_r%0d", i), 0, 1);
    end
    cyc(); w1 = 1; a1 = 32'h77; #1;
    chk("t4_pend4", 32'(pend), 4);
    chk("t4_wr", 32'(o_write), 1);
    grant("t4_w", 1, 0);
    cyc(); w1 = 0; rdv = 1; rdata = 32'h11; #1;
    chk("t4_full_rd", 32'(o_read), 0);
    chk("t4_full_ack", 32'(ack0), 0);
    rsp("t4_rsp0", 32'h11);
    cyc(); rdv = 0; #1;
    chk("t4_pend3", 32'(pend), 3);
    grant("t4_r5", 0, 1);
    cyc(); r0 = 0;
    for (int i = 1; i <= 4; i++) begin
      rdv = 1; rdata = 32'h20 + 32'(i); #1; rsp($sformatf("t4_d%0d", i), 32'h20 + 32'(i));
      cyc();
    end
    rdv = 0; #1; chk("t4_pend0", 32'(pend), 0);
    // unsolicited response
    cyc(); rdv = 1; rdata = 32'h99; #1;
    chk("t5_v0", 32'(v0), 0);
    chk("t5_v1", 32'(v1), 0);
    cyc(); rdv = 0; #1; chk("t5_err", 32'(o_err), 1);
    cyc(); #1; chk("t5_err_sticky", 32'(o_err), 1);
    do_reset(); #1; chk("t5_err_clr", 32'(o_err), 0);
    // async reset mid-stall with two reads pending
    a0 = 32'h400; a1 = 32'h500;
    cyc(); r0 = 1; #1; grant("t6_a", 0, 1);
    cyc(); r0 = 0; r1 = 1; #1; grant("t6_b", 1, 1);
    cyc(); r1 = 0; r0 = 1; wait_r = 1; #1;
    chk("t6_stall_rd", 32'(o_read), 1);
    chk("t6_pend2", 32'(pend), 2);
    #1 rst = 1; #1;
    chk("t6_rst_rd", 32'(o_read), 0);
    chk("t6_rst_pend", 32'(pend), 0);
    sb.delete();
    idle(); #1 rst = 0;
    cyc(); rdv = 1; rdata = 32'h5; #1;
    chk("t6_v0", 32'(v0), 0);
    chk("t6_v1", 32'(v1), 0);
    cyc(); rdv = 0; #1; chk("t6_err", 32'(o_err), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
